// File: rtl/wire_alu_sweep_if.sv
// Host-side bundle for wire_alu_sweep: wire-in operands/modes and trigger bits in,
// registered results and status out. Flat vectors, channel k at [k*W +: W].
interface wire_alu_sweep_if #(
  parameter int W    = 32,
  parameter int N_CH = 4
);
  logic                  start;
  logic                  clr_flags;
  logic [2*N_CH-1:0]     mode_in;
  logic [W*N_CH-1:0]     op_a;
  logic [W*N_CH-1:0]     op_b;
  logic [W*N_CH-1:0]     result;
  logic [N_CH-1:0]       ovf;
  logic                  busy;
  logic                  done;
  logic                  start_dropped;
  logic [15:0]           sweep_count;

  modport master (
    output start, clr_flags, mode_in, op_a, op_b,
    input  result, ovf, busy, done, start_dropped, sweep_count
  );

  modport slave (
    input  start, clr_flags, mode_in, op_a, op_b,
    output result, ovf, busy, done, start_dropped, sweep_count
  );
endinterface

// File: rtl/wire_alu_sweep.sv
// N_CH operand channels served by one shared W-bit ALU, one channel per clock after
// each start strobe. Inputs are snapshotted at start; results and flags are registered.
module wire_alu_sweep #(
  parameter int W        = 32,
  parameter int N_CH     = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic           okClk,
  input  logic           rst_n,
  wire_alu_sweep_if.slave bus
);
  localparam int            IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ACC = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e                   state_q;
  logic [IW-1:0]            idx_q;
  logic [N_CH-1:0][W-1:0]   a_sh_q, b_sh_q;
  logic [N_CH-1:0][1:0]     mode_sh_q;
  logic                     busy_q, done_q, drop_q;
  logic [15:0]              cnt_q;

  logic [N_CH-1:0][W-1:0]   res_w;
  logic [N_CH-1:0]          ovf_w;
  logic [N_CH-1:0]          wr_en;

  logic [W-1:0]             alu_a, alu_b, alu_r, alu_val;
  logic [1:0]               alu_mode;
  logic [W:0]               alu_sum;
  logic                     alu_flag;

  // Channel mux written as a compare loop so idx width never has to match the array.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_r    = '0;
    alu_mode = '0;
    wr_en    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx_q == IW'(k)) begin
        alu_a    = a_sh_q[k];
        alu_b    = b_sh_q[k];
        alu_r    = res_w[k];
        alu_mode = mode_sh_q[k];
        wr_en[k] = (state_q == RUN);
      end
    end
  end

  always_comb begin
    alu_sum  = '0;
    alu_val  = '0;
    alu_flag = 1'b0;
    case (alu_mode)
      MODE_ADD: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flag = alu_sum[W];
        alu_val  = (alu_flag && SATURATE) ? '1 : alu_sum[W-1:0];
      end
      MODE_SUB: begin
        alu_flag = (alu_b > alu_a);
        alu_val  = (alu_flag && SATURATE) ? '0 : (alu_a - alu_b);
      end
      MODE_ACC: begin
        alu_sum  = {1'b0, alu_r} + {1'b0, alu_a};
        alu_flag = alu_sum[W];
        alu_val  = (alu_flag && SATURATE) ? '1 : alu_sum[W-1:0];
      end
      default: begin
        alu_val  = '0;
        alu_flag = 1'b0;
      end
    endcase
  end

  // Per-channel result and sticky flag; a flag set beats a coincident clear.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [W-1:0] r_q;
    logic         o_q;

    always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        o_q <= 1'b0;
      end else begin
        if (wr_en[k]) r_q <= alu_val;
        if (wr_en[k] && alu_flag) o_q <= 1'b1;
        else if (bus.clr_flags)   o_q <= 1'b0;
      end
    end

    assign res_w[k] = r_q;
    assign ovf_w[k] = o_q;
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      mode_sh_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start && busy_q) drop_q <= 1'b1;
      else if (bus.clr_flags)  drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q    <= bus.op_a;
            b_sh_q    <= bus.op_b;
            mode_sh_q <= bus.mode_in;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= cnt_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result        = res_w;
  assign bus.ovf           = ovf_w;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.start_dropped = drop_q;
  assign bus.sweep_count   = cnt_q;
endmodule

// File: tb/tb_wire_alu_sweep.sv
// Bench for wire_alu_sweep: wrap and saturate variants share stimulus, plus an N_CH=1 copy.
module tb_wire_alu_sweep;
  logic okClk;
  logic rst_n;
  int   total;
  int   bad;

  wire_alu_sweep_if #(.W(32), .N_CH(4)) ifA ();
  wire_alu_sweep_if #(.W(32), .N_CH(4)) ifB ();
  wire_alu_sweep_if #(.W(32), .N_CH(1)) ifC ();

  wire_alu_sweep #(.W(32), .N_CH(4), .SATURATE(1'b0)) u_wrap (.okClk(okClk), .rst_n(rst_n), .bus(ifA));
  wire_alu_sweep #(.W(32), .N_CH(4), .SATURATE(1'b1)) u_sat  (.okClk(okClk), .rst_n(rst_n), .bus(ifB));
  wire_alu_sweep #(.W(32), .N_CH(1), .SATURATE(1'b0)) u_one  (.okClk(okClk), .rst_n(rst_n), .bus(ifC));

  assign ifB.start     = ifA.start;
  assign ifB.clr_flags = ifA.clr_flags;
  assign ifB.mode_in   = ifA.mode_in;
  assign ifB.op_a      = ifA.op_a;
  assign ifB.op_b      = ifA.op_b;

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  // Reference state: [0] wrap variant, [1] saturate variant.
  logic [31:0] mr [2][4];
  logic [3:0]  mo [2];

  typedef struct packed {
    logic [7:0]   mode;
    logic [127:0] a, b, r0, r1;
    logic [3:0]   o0, o1;
  } vec_t;
  vec_t tbl [3];

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [127:0] mvec(input int s);
    return {mr[s][3], mr[s][2], mr[s][1], mr[s][0]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mo[s] = '0;
      for (int k = 0; k < 4; k++) mr[s][k] = '0;
    end
  endtask

  // Arithmetic in 64 bits; anything above 2^32-1 or a negative difference is a flag.
  task automatic model_sweep(input logic [7:0] m, input logic [127:0] a, input logic [127:0] b);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        logic [63:0] x, y, t;
        logic        f;
        x = 64'(a[32*k +: 32]);
        y = 64'(b[32*k +: 32]);
        f = 1'b0;
        case (m[2*k +: 2])
          2'd0: begin
            t = x + y;
            f = t > 64'hFFFF_FFFF;
            if (f && s == 1) t = 64'hFFFF_FFFF;
          end
          2'd1: begin
            f = y > x;
            t = f ? ((s == 1) ? 64'd0 : (x + 64'h1_0000_0000 - y)) : (x - y);
          end
          2'd2: begin
            t = 64'(mr[s][k]) + x;
            f = t > 64'hFFFF_FFFF;
            if (f && s == 1) t = 64'hFFFF_FFFF;
          end
          default: t = 64'd0;
        endcase
        mr[s][k] = t[31:0];
        if (f) mo[s][k] = 1'b1;
      end
    end
  endtask

  // One sweep on the shared stimulus; optionally scrambles inputs after the snapshot edge.
  task automatic sweep(input logic [7:0] m, input logic [127:0] a, input logic [127:0] b, input bit scramble);
    bit got;
    ifA.mode_in = m;
    ifA.op_a    = a;
    ifA.op_b    = b;
    ifA.start   = 1'b1;
    tick();
    ifA.start   = 1'b0;
    if (scramble) begin
      ifA.mode_in = 8'($urandom);
      ifA.op_a    = {$urandom, $urandom, $urandom, $urandom};
      ifA.op_b    = {$urandom, $urandom, $urandom, $urandom};
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ifA.done) got = 1'b1;
    end
    chk("sweep_done_seen", 128'(got), 128'd1);
  endtask

  initial begin
    int nbA, nbC, ndA, ndC, nd;
    bit got;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifA.start = 1'b0; ifA.clr_flags = 1'b0; ifA.mode_in = '0; ifA.op_a = '0; ifA.op_b = '0;
    ifC.start = 1'b0; ifC.clr_flags = 1'b0; ifC.mode_in = '0; ifC.op_a = '0; ifC.op_b = '0;

    tbl[0] = '{mode: 8'h00,
               a:  {32'h8000_0000, 32'd10, 32'hFFFF_FFFF, 32'd5},
               b:  {32'h7FFF_FFFF, 32'd20, 32'd1, 32'd7},
               r0: {32'hFFFF_FFFF, 32'd30, 32'd0, 32'd12},
               r1: {32'hFFFF_FFFF, 32'd30, 32'hFFFF_FFFF, 32'd12},
               o0: 4'b0010, o1: 4'b0010};
    tbl[1] = '{mode: 8'hDA,
               a:  {32'd0, 32'd3, 32'hFFFF_FFFF, 32'd3},
               b:  {32'd0, 32'd10, 32'd0, 32'd0},
               r0: {32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd15},
               r1: {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd15},
               o0: 4'b0110, o1: 4'b0110};
    tbl[2] = '{mode: 8'h39,
               a:  {32'd1, 32'd0, 32'hFFFF_FFFF, 32'd9},
               b:  {32'd2, 32'd0, 32'd0, 32'd9},
               r0: {32'd3, 32'd0, 32'hFFFF_FFFE, 32'd0},
               r1: {32'd3, 32'd0, 32'hFFFF_FFFF, 32'd0},
               o0: 4'b0110, o1: 4'b0110};

    #12;
    chk("rst_result", ifA.result, 128'd0);
    chk("rst_ovf", 128'(ifA.ovf), 128'd0);
    chk("rst_busy_done", {ifA.busy, ifA.done, ifA.start_dropped}, 128'd0);
    chk("rst_count", 128'(ifA.sweep_count), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-channel add on both 4-channel and 1-channel copies, cycle by cycle.
    ifA.op_a = {96'd0, 32'd5}; ifA.op_b = {96'd0, 32'd7};
    ifC.op_a = 32'd5;          ifC.op_b = 32'd7;
    ifA.start = 1'b1; ifC.start = 1'b1;
    tick();
    ifA.start = 1'b0; ifC.start = 1'b0;
    nbA = 0; nbC = 0; ndA = 0; ndC = 0;
    for (int c = 0; c < 8; c++) begin
      if (ifA.busy) nbA++;
      if (ifC.busy) nbC++;
      if (ifA.done) begin ndA++; chk("t1_done_edge", 128'(c), 128'd5); end
      if (ifC.done) begin ndC++; chk("n1_done_edge", 128'(c), 128'd2); end
      if (c == 0) chk("t1_res0_before", 128'(ifA.result[31:0]), 128'd0);
      if (c == 1) chk("t1_res0_e1", 128'(ifA.result[31:0]), 128'd12);
      tick();
    end
    chk("t1_busy_cycles", 128'(nbA), 128'd5);
    chk("t1_done_count", 128'(ndA), 128'd1);
    chk("t1_sweep_count", 128'(ifA.sweep_count), 128'd1);
    chk("n1_busy_cycles", 128'(nbC), 128'd2);
    chk("n1_done_count", 128'(ndC), 128'd1);
    chk("n1_result", 128'(ifC.result), 128'd12);

    // Table of back-to-back sweeps covering every mode and both overflow directions.
    for (int i = 0; i < 3; i++) begin
      sweep(tbl[i].mode, tbl[i].a, tbl[i].b, 1'b1);
      chk($sformatf("tbl%0d_res_wrap", i), ifA.result, tbl[i].r0);
      chk($sformatf("tbl%0d_res_sat", i),  ifB.result, tbl[i].r1);
      chk($sformatf("tbl%0d_ovf_wrap", i), 128'(ifA.ovf), 128'(tbl[i].o0));
      chk($sformatf("tbl%0d_ovf_sat", i),  128'(ifB.ovf), 128'(tbl[i].o1));
    end
    chk("tbl_sweep_count", 128'(ifA.sweep_count), 128'd4);

    ifA.clr_flags = 1'b1;
    tick();
    ifA.clr_flags = 1'b0;
    chk("clr_ovf_wrap", 128'(ifA.ovf), 128'd0);
    chk("clr_ovf_sat", 128'(ifB.ovf), 128'd0);
    chk("clr_keeps_result", ifA.result, tbl[2].r0);

    // Snapshot isolation and dropped start.
    ifA.mode_in = 8'h00;
    ifA.op_a = {32'd4, 32'd3, 32'd2, 32'd1};
    ifA.op_b = {32'd40, 32'd30, 32'd20, 32'd10};
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    ifA.op_a = {4{32'hFFFF_FFFF}};
    tick();
    chk("snap_ch0_e1", 128'(ifA.result[31:0]), 128'd11);
    chk("unswept_ch1_kept", 128'(ifA.result[63:32]), 128'hFFFF_FFFE);
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    chk("drop_set", 128'(ifA.start_dropped), 128'd1);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifA.done) nd++;
      tick();
    end
    chk("drop_one_done", 128'(nd), 128'd1);
    chk("snap_result_wrap", ifA.result, {32'd44, 32'd33, 32'd22, 32'd11});
    chk("snap_result_sat", ifB.result, {32'd44, 32'd33, 32'd22, 32'd11});
    chk("snap_no_ovf", 128'(ifA.ovf), 128'd0);

    ifA.clr_flags = 1'b1;
    tick();
    ifA.clr_flags = 1'b0;
    chk("drop_cleared", 128'(ifA.start_dropped), 128'd0);
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    tick();
    ifA.start = 1'b1; ifA.clr_flags = 1'b1;
    tick();
    ifA.start = 1'b0; ifA.clr_flags = 1'b0;
    chk("drop_beats_clr", 128'(ifA.start_dropped), 128'd1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (ifA.done) got = 1'b1;
    end
    chk("drop_sweep_done", 128'(got), 128'd1);
    tick();

    // Asynchronous reset two edges into a sweep.
    ifA.mode_in = tbl[0].mode; ifA.op_a = tbl[0].a; ifA.op_b = tbl[0].b;
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_result", ifA.result, 128'd0);
    chk("arst_flags", {ifA.ovf, ifA.start_dropped, ifA.busy, ifA.done}, 128'd0);
    chk("arst_count", 128'(ifA.sweep_count), 128'd0);
    chk("arst_sat_busy", 128'(ifB.busy), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();

    // Random sweeps against the reference model, inputs scrambled mid-sweep.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]   m;
      logic [127:0] a, b;
      m = 8'($urandom);
      a = {pick(), pick(), pick(), pick()};
      b = {pick(), pick(), pick(), pick()};
      model_sweep(m, a, b);
      sweep(m, a, b, 1'b1);
      chk($sformatf("rnd%0d_res_wrap", n), ifA.result, mvec(0));
      chk($sformatf("rnd%0d_res_sat", n),  ifB.result, mvec(1));
      chk($sformatf("rnd%0d_ovf_wrap", n), 128'(ifA.ovf), 128'(mo[0]));
      chk($sformatf("rnd%0d_ovf_sat", n),  128'(ifB.ovf), 128'(mo[1]));
    end
    chk("rnd_sweep_count", 128'(ifA.sweep_count), 128'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
